// File: rtl/hls_stream_arbiter.sv
// Shares one ap_fifo HLS core between two FIFO requesters, one header-framed packet at a time.
// Header word: [CNT_W-1:0] payload length L, [16+CNT_W-1:16] expected result count R.
module hls_stream_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        bus_clk,
  input  logic        srst,
  input  logic        ch0_empty,
  output logic        ch0_rd_en,
  input  logic [31:0] ch0_dout,
  input  logic        ch0_open,
  output logic [31:0] ch0_out_din,
  output logic        ch0_out_wr_en,
  input  logic        ch0_out_full,
  input  logic        ch1_empty,
  output logic        ch1_rd_en,
  input  logic [31:0] ch1_dout,
  input  logic        ch1_open,
  output logic [31:0] ch1_out_din,
  output logic        ch1_out_wr_en,
  input  logic        ch1_out_full,
  output logic [31:0] in_r_dout,
  output logic        in_r_empty_n,
  input  logic        in_r_read,
  input  logic [31:0] out_r_din,
  input  logic        out_r_write,
  output logic        out_r_full_n,
  output logic        core_rst,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err_orphan
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

  state_t             state;
  logic               gsel;
  logic               last;
  logic [CNT_W-1:0]   l_len;
  logic [CNT_W-1:0]   req_cnt;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic               hold_valid;
  logic [31:0]        hold_data;
  logic               rd_pending;
  logic               core_rst_q;

  logic               q0, q1, pick, start;
  logic               g_empty, g_open, g_full;
  logic [31:0]        g_dout;
  logic               active, abort, pay_rd, pop, accept, wr_ok, orphan_wr;
  logic [CNT_W-1:0]   hdr_l, hdr_r;

  // Requester qualification and round-robin pick (the channel not granted last wins a tie)
  assign q0    = !ch0_empty && ch0_open;
  assign q1    = !ch1_empty && ch1_open;
  assign pick  = (q0 && q1) ? !last : q1;
  assign start = (state == IDLE) && (q0 || q1);

  assign g_empty = gsel ? ch1_empty    : ch0_empty;
  assign g_open  = gsel ? ch1_open     : ch0_open;
  assign g_full  = gsel ? ch1_out_full : ch0_out_full;
  assign g_dout  = gsel ? ch1_dout     : ch0_dout;

  assign hdr_l = g_dout[CNT_W-1:0];
  assign hdr_r = g_dout[16 +: CNT_W];

  assign active = (state == PAYLOAD) || (state == DRAIN);
  assign abort  = (state != IDLE) && !g_open;

  // A read is only issued when no word is still in flight, so the single holding slot never overflows
  assign pay_rd = (state == PAYLOAD) && !abort && !g_empty && !rd_pending &&
                  (!hold_valid || in_r_read) && (req_cnt < l_len);
  assign pop    = hold_valid && in_r_read;

  assign ch0_rd_en = (start && !pick) || (pay_rd && !gsel);
  assign ch1_rd_en = (start &&  pick) || (pay_rd &&  gsel);

  assign in_r_dout    = hold_data;
  assign in_r_empty_n = hold_valid;

  // Result routing; unexpected writes are swallowed with full_n held high so the core cannot stall
  assign accept        = active && (out_cnt != '0);
  assign out_r_full_n  = accept ? !g_full : 1'b1;
  assign wr_ok         = accept && out_r_write && !g_full;
  assign orphan_wr     = out_r_write && !accept;
  assign ch0_out_din   = out_r_din;
  assign ch1_out_din   = out_r_din;
  assign ch0_out_wr_en = wr_ok && !gsel;
  assign ch1_out_wr_en = wr_ok &&  gsel;

  assign core_rst = srst || core_rst_q;

  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state      <= IDLE;
      gsel       <= 1'b0;
      last       <= 1'b1;
      l_len      <= '0;
      req_cnt    <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      rd_pending <= 1'b0;
      core_rst_q <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      core_rst_q <= 1'b0;
      rd_pending <= pay_rd;
      if (orphan_wr) err_orphan <= 1'b1;
      if (wr_ok) out_cnt <= out_cnt - CNT_W'(1);

      if (abort) begin
        state      <= IDLE;
        grant      <= 2'b00;
        busy       <= 1'b0;
        last       <= gsel;
        core_rst_q <= 1'b1;
        hold_valid <= 1'b0;
        req_cnt    <= '0;
        in_cnt     <= '0;
        out_cnt    <= '0;
        rd_pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              gsel  <= pick;
              grant <= pick ? 2'b10 : 2'b01;
              busy  <= 1'b1;
              state <= HDR;
            end
          end
          HDR: begin
            l_len      <= hdr_l;
            in_cnt     <= hdr_l;
            out_cnt    <= hdr_r;
            req_cnt    <= '0;
            hold_valid <= 1'b0;
            if (hdr_l != '0) begin
              state <= PAYLOAD;
            end else if (hdr_r != '0) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
              busy  <= 1'b0;
              last  <= gsel;
            end
          end
          PAYLOAD: begin
            if (pay_rd) req_cnt <= req_cnt + CNT_W'(1);
            if (rd_pending) begin
              hold_data  <= g_dout;
              hold_valid <= 1'b1;
            end else if (pop) begin
              hold_valid <= 1'b0;
            end
            if (pop && (in_cnt != '0)) begin
              in_cnt <= in_cnt - CNT_W'(1);
              if (in_cnt == CNT_W'(1)) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (out_cnt == '0) begin
              state <= IDLE;
              grant <= 2'b00;
              busy  <= 1'b0;
              last  <= gsel;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hls_stream_arbiter.sv
// Directed bench: two requester FIFO models, a scripted HLS core and per-scenario checks.
module tb_hls_stream_arbiter;

  logic        bus_clk = 1'b0;
  logic        srst = 1'b1;
  logic        ch0_empty = 1'b1, ch1_empty = 1'b1;
  logic        ch0_rd_en, ch1_rd_en;
  logic [31:0] ch0_dout = '0, ch1_dout = '0;
  logic        ch0_open = 1'b1, ch1_open = 1'b1;
  logic [31:0] ch0_out_din, ch1_out_din;
  logic        ch0_out_wr_en, ch1_out_wr_en;
  logic        ch0_out_full = 1'b0, ch1_out_full = 1'b0;
  logic [31:0] in_r_dout;
  logic        in_r_empty_n;
  logic        in_r_read = 1'b0;
  logic [31:0] out_r_din = '0;
  logic        out_r_write = 1'b0;
  logic        out_r_full_n;
  logic        core_rst;
  logic [1:0]  grant;
  logic        busy;
  logic        err_orphan;

  int checks = 0;
  int errors = 0;

  hls_stream_arbiter #(.CNT_W(16)) dut (
    .bus_clk(bus_clk), .srst(srst),
    .ch0_empty(ch0_empty), .ch0_rd_en(ch0_rd_en), .ch0_dout(ch0_dout), .ch0_open(ch0_open),
    .ch0_out_din(ch0_out_din), .ch0_out_wr_en(ch0_out_wr_en), .ch0_out_full(ch0_out_full),
    .ch1_empty(ch1_empty), .ch1_rd_en(ch1_rd_en), .ch1_dout(ch1_dout), .ch1_open(ch1_open),
    .ch1_out_din(ch1_out_din), .ch1_out_wr_en(ch1_out_wr_en), .ch1_out_full(ch1_out_full),
    .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n), .in_r_read(in_r_read),
    .out_r_din(out_r_din), .out_r_write(out_r_write), .out_r_full_n(out_r_full_n),
    .core_rst(core_rst), .grant(grant), .busy(busy), .err_orphan(err_orphan)
  );

  always #5 bus_clk = ~bus_clk;

  // Standard (non-FWFT) FIFO models: tasks fill mem/wp, this block owns rp/dout/empty
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0;
  int rd0_cnt = 0, rd1_cnt = 0, wr0_cnt = 0, wr1_cnt = 0;
  logic [31:0] log0 [64];
  logic [31:0] log1 [64];

  always @(posedge bus_clk) begin
    rd0_cnt <= rd0_cnt + int'(ch0_rd_en);
    rd1_cnt <= rd1_cnt + int'(ch1_rd_en);
    if (ch0_rd_en && !ch0_empty) begin
      ch0_dout <= mem0[rp0 % 64];
      rp0      <= rp0 + 1;
    end
    if (ch1_rd_en && !ch1_empty) begin
      ch1_dout <= mem1[rp1 % 64];
      rp1      <= rp1 + 1;
    end
    ch0_empty <= (((ch0_rd_en && !ch0_empty) ? rp0 + 1 : rp0) == wp0);
    ch1_empty <= (((ch1_rd_en && !ch1_empty) ? rp1 + 1 : rp1) == wp1);
    if (ch0_out_wr_en) begin
      log0[wr0_cnt % 64] <= ch0_out_din;
      wr0_cnt            <= wr0_cnt + 1;
    end
    if (ch1_out_wr_en) begin
      log1[wr1_cnt % 64] <= ch1_out_din;
      wr1_cnt            <= wr1_cnt + 1;
    end
  end

  // Scripted core state
  logic [31:0] res_q[$];
  logic [31:0] in_words[$];
  logic        core_rd = 1'b1;
  logic        core_wr = 1'b1;
  logic        echo = 1'b0;

  task automatic push(input int ch, input logic [31:0] w);
    if (ch == 0) begin
      mem0[wp0 % 64] = w;
      wp0 = wp0 + 1;
    end else begin
      mem1[wp1 % 64] = w;
      wp1 = wp1 + 1;
    end
  endtask

  // One clock of the core: decide at negedge, commit at posedge, return 1 time unit later
  task automatic step();
    logic [31:0] word;
    @(negedge bus_clk);
    in_r_read   = core_rd && in_r_empty_n;
    out_r_write = core_wr && (res_q.size() > 0) && out_r_full_n;
    out_r_din   = (res_q.size() > 0) ? res_q[0] : 32'h0;
    word        = in_r_dout;
    @(posedge bus_clk);
    if (in_r_read) begin
      in_words.push_back(word);
      if (echo) res_q.push_back(word + 32'h100);
    end
    if (out_r_write) void'(res_q.pop_front());
    #1;
  endtask

  task automatic apply_reset();
    srst = 1'b1;
    step();
    step();
    srst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step();
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b exp 1", core_rst); end
    checks++; if (in_r_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got %b exp 0", in_r_empty_n); end
    checks++; if (out_r_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n got %b exp 1", out_r_full_n); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan got %b exp 0", err_orphan); end
    checks++; if ({ch0_rd_en, ch1_rd_en, ch0_out_wr_en, ch1_out_wr_en} !== 4'b0) begin
      errors++; $display("FAIL reset_enables got %b exp 0000", {ch0_rd_en, ch1_rd_en, ch0_out_wr_en, ch1_out_wr_en});
    end
    srst = 1'b0;
    step();
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL reset_release_core_rst got %b exp 0", core_rst); end
  endtask

  task automatic test_basic();
    int b_in, b_rd, b_wr0, b_wr1, n;
    b_in = in_words.size(); b_rd = rd0_cnt; b_wr0 = wr0_cnt; b_wr1 = wr1_cnt;
    echo = 1'b0; core_rd = 1'b1;
    push(0, 32'h0002_0003); push(0, 32'd11); push(0, 32'd22); push(0, 32'd33);
    for (int i = 0; i < 100 && in_words.size() < b_in + 3; i++) step();
    checks++; if (in_words.size() != b_in + 3) begin errors++; $display("FAIL basic_in_count got %0d exp 3", in_words.size() - b_in); end
    else begin
      checks++; if (in_words[b_in] !== 32'd11 || in_words[b_in+1] !== 32'd22 || in_words[b_in+2] !== 32'd33) begin
        errors++; $display("FAIL basic_payload got %h %h %h exp 0b 16 21", in_words[b_in], in_words[b_in+1], in_words[b_in+2]);
      end
    end
    checks++; if (grant !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL basic_grant got %b/%b exp 01/1", grant, busy); end
    res_q.push_back(32'hC0DE_0001); res_q.push_back(32'hC0DE_0002);
    n = 0;
    while (n < 100 && wr0_cnt < b_wr0 + 2) begin step(); n++; end
    checks++; if (wr0_cnt - b_wr0 != 2) begin errors++; $display("FAIL basic_wr_count got %0d exp 2", wr0_cnt - b_wr0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_last_write got %b exp 1", busy); end
    step();
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL basic_return_idle got %b/%b exp 0/00", busy, grant); end
    checks++; if (log0[b_wr0 % 64] !== 32'hC0DE_0001 || log0[(b_wr0+1) % 64] !== 32'hC0DE_0002) begin
      errors++; $display("FAIL basic_result_data got %h %h exp c0de0001 c0de0002", log0[b_wr0 % 64], log0[(b_wr0+1) % 64]);
    end
    checks++; if (rd0_cnt - b_rd != 4) begin errors++; $display("FAIL basic_rd_pulses got %0d exp 4", rd0_cnt - b_rd); end
    checks++; if (wr1_cnt != b_wr1) begin errors++; $display("FAIL basic_ch1_writes got %0d exp 0", wr1_cnt - b_wr1); end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [3];
    logic [1:0] prev;
    int gcnt, b_in, b_wr0, b_wr1;
    apply_reset();
    gcnt = 0; prev = 2'b00;
    b_in = in_words.size(); b_wr0 = wr0_cnt; b_wr1 = wr1_cnt;
    echo = 1'b1; core_rd = 1'b1;
    push(0, 32'h0001_0001); push(0, 32'h10); push(0, 32'h0001_0001); push(0, 32'h30);
    push(1, 32'h0001_0001); push(1, 32'h20);
    for (int i = 0; i < 300 && !(gcnt == 3 && busy == 1'b0); i++) begin
      step();
      if (grant != 2'b00 && prev == 2'b00 && gcnt < 3) begin seq[gcnt] = grant; gcnt++; end
      prev = grant;
    end
    checks++; if (gcnt != 3 || busy !== 1'b0) begin errors++; $display("FAIL rr_grants got %0d busy %b exp 3 busy 0", gcnt, busy); end
    else begin
      checks++; if (seq[0] !== 2'b01 || seq[1] !== 2'b10 || seq[2] !== 2'b01) begin
        errors++; $display("FAIL rr_order got %b %b %b exp 01 10 01", seq[0], seq[1], seq[2]);
      end
    end
    checks++; if (in_words.size() != b_in + 3 || in_words[b_in] !== 32'h10 || in_words[b_in+1] !== 32'h20) begin
      errors++; $display("FAIL rr_payload_order got %0d words exp 10 20 30", in_words.size() - b_in);
    end
    checks++; if (wr0_cnt - b_wr0 != 2 || wr1_cnt - b_wr1 != 1) begin
      errors++; $display("FAIL rr_writes got %0d/%0d exp 2/1", wr0_cnt - b_wr0, wr1_cnt - b_wr1);
    end
    checks++; if (log1[b_wr1 % 64] !== 32'h120) begin errors++; $display("FAIL rr_ch1_data got %h exp 00000120", log1[b_wr1 % 64]); end
    echo = 1'b0;
  endtask

  task automatic test_backpressure();
    int b_in, b_wr1, n;
    logic seen_fulln_low;
    b_in = in_words.size(); b_wr1 = wr1_cnt;
    ch1_out_full = 1'b1; core_rd = 1'b1; echo = 1'b0;
    push(1, 32'h0003_0001); push(1, 32'h55);
    for (int i = 0; i < 100 && in_words.size() < b_in + 1; i++) step();
    checks++; if (in_words.size() != b_in + 1) begin errors++; $display("FAIL bp_in_count got %0d exp 1", in_words.size() - b_in); end
    res_q.push_back(32'hD1); res_q.push_back(32'hD2); res_q.push_back(32'hD3);
    seen_fulln_low = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); if (out_r_full_n !== 1'b0) seen_fulln_low = 1'b0; end
    checks++; if (seen_fulln_low !== 1'b1) begin errors++; $display("FAIL bp_full_n got %b exp 0", out_r_full_n); end
    checks++; if (wr1_cnt != b_wr1 || busy !== 1'b1) begin errors++; $display("FAIL bp_stalled got %0d writes busy %b exp 0 busy 1", wr1_cnt - b_wr1, busy); end
    ch1_out_full = 1'b0;
    n = 0;
    while (n < 50 && wr1_cnt < b_wr1 + 3) begin step(); n++; end
    checks++; if (wr1_cnt - b_wr1 != 3) begin errors++; $display("FAIL bp_delivered got %0d exp 3", wr1_cnt - b_wr1); end
    checks++; if (log1[b_wr1 % 64] !== 32'hD1 || log1[(b_wr1+1) % 64] !== 32'hD2 || log1[(b_wr1+2) % 64] !== 32'hD3) begin
      errors++; $display("FAIL bp_data got %h %h %h exp d1 d2 d3", log1[b_wr1 % 64], log1[(b_wr1+1) % 64], log1[(b_wr1+2) % 64]);
    end
    step();
    checks++; if (busy !== 1'b0 || res_q.size() != 0) begin errors++; $display("FAIL bp_idle got busy %b pending %0d exp 0 0", busy, res_q.size()); end
  endtask

  task automatic test_zero_header();
    int b_rd;
    logic saw_grant, saw_data;
    b_rd = rd0_cnt; saw_grant = 1'b0; saw_data = 1'b0;
    push(0, 32'h0000_0000);
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant == 2'b01) saw_grant = 1'b1;
      if (in_r_empty_n !== 1'b0) saw_data = 1'b1;
    end
    checks++; if (rd0_cnt - b_rd != 1) begin errors++; $display("FAIL zero_rd_pulses got %0d exp 1", rd0_cnt - b_rd); end
    checks++; if (saw_grant !== 1'b1) begin errors++; $display("FAIL zero_granted got %b exp 1", saw_grant); end
    checks++; if (saw_data !== 1'b0) begin errors++; $display("FAIL zero_empty_n got %b exp 0", saw_data); end
    checks++; if (busy !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL zero_idle got %b/%b exp 0/00", busy, grant); end
  endtask

  task automatic test_orphan();
    int b_wr0, b_wr1;
    b_wr0 = wr0_cnt; b_wr1 = wr1_cnt;
    checks++; if (err_orphan !== 1'b0 || out_r_full_n !== 1'b1) begin
      errors++; $display("FAIL orphan_pre got %b full_n %b exp 0 1", err_orphan, out_r_full_n);
    end
    res_q.push_back(32'hBAD);
    step();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
    checks++; if (wr0_cnt != b_wr0 || wr1_cnt != b_wr1) begin
      errors++; $display("FAIL orphan_no_writes got %0d/%0d exp 0/0", wr0_cnt - b_wr0, wr1_cnt - b_wr1);
    end
    apply_reset();
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_cleared got %b exp 0", err_orphan); end
  endtask

  task automatic test_abort();
    int b_in, b_wr0, b_wr1, n;
    apply_reset();
    b_in = in_words.size(); b_wr0 = wr0_cnt; b_wr1 = wr1_cnt;
    core_rd = 1'b1; echo = 1'b0;
    push(0, 32'h0005_0005);
    for (int k = 1; k <= 5; k++) push(0, 32'(k));
    push(1, 32'h0001_0001); push(1, 32'h77);
    for (int i = 0; i < 100 && in_words.size() < b_in + 2; i++) step();
    checks++; if (in_words.size() != b_in + 2 || grant !== 2'b01) begin
      errors++; $display("FAIL abort_setup got %0d words grant %b exp 2 01", in_words.size() - b_in, grant);
    end
    core_rd = 1'b0;
    checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL abort_pre_core_rst got %b exp 0", core_rst); end
    ch0_open = 1'b0;
    step();
    checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || grant !== 2'b00 || in_r_empty_n !== 1'b0) begin
      errors++; $display("FAIL abort_pulse got rst %b busy %b grant %b empty_n %b exp 1 0 00 0", core_rst, busy, grant, in_r_empty_n);
    end
    step();
    checks++; if (core_rst !== 1'b0 || grant !== 2'b10) begin
      errors++; $display("FAIL abort_next got rst %b grant %b exp 0 10", core_rst, grant);
    end
    core_rd = 1'b1; echo = 1'b1;
    n = 0;
    while (n < 100 && wr1_cnt < b_wr1 + 1) begin step(); n++; end
    checks++; if (wr1_cnt - b_wr1 != 1 || log1[b_wr1 % 64] !== 32'h177) begin
      errors++; $display("FAIL abort_ch1_service got %0d writes data %h exp 1 00000177", wr1_cnt - b_wr1, log1[b_wr1 % 64]);
    end
    checks++; if (wr0_cnt != b_wr0 || err_orphan !== 1'b0) begin
      errors++; $display("FAIL abort_ch0_quiet got %0d writes orphan %b exp 0 0", wr0_cnt - b_wr0, err_orphan);
    end
    echo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_zero_header();
    test_orphan();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
